// File: rtl/lsu_if.sv
// AXI read-data / write-response channel pair seen by the LSU.
// master: the LSU side (consumes R and B beats, drives the ready signals).
// slave : the memory/interconnect side (drives beats, observes ready).
//   rvalid_i / rdata_i / rresp_i / rready_o : AXI R channel
//   bvalid_i / bresp_i / bready_o           : AXI B channel
interface lsu_if;
  logic        rvalid_i;
  logic [31:0] rdata_i;
  logic [1:0]  rresp_i;
  logic        rready_o;
  logic        bvalid_i;
  logic [1:0]  bresp_i;
  logic        bready_o;

  modport master (
    input  rvalid_i, rdata_i, rresp_i, bvalid_i, bresp_i,
    output rready_o, bready_o
  );

  modport slave (
    output rvalid_i, rdata_i, rresp_i, bvalid_i, bresp_i,
    input  rready_o, bready_o
  );
endinterface

// File: rtl/lsu.sv
// Memory-response stage between execute and write-back.
// Takes an instruction from execute (whose AXI address/write handshake is
// already done), waits for the matching R or B beat, aligns and extends load
// data, and presents the result to write-back. Flushes drain any response
// still outstanding so it can never be mistaken for a later instruction's.
// Ports:
//   clock, reset           : clock, synchronous active-high reset
//   excp_flush, mret_flush : pipeline flush requests
//   exu_valid_i, exu_lsu_bus_i, exu_excp_bus_i, lsu_ready_o : execute handshake
//   axi                    : AXI R/B response channels (lsu_if.master)
//   wbu_ready_i, valid_o, lsu_wbu_bus_o : write-back handshake
//   lsu_excp_bus_o         : {load_access_fault, store_access_fault, exu excp[6:0]}
//   lsu_forward_bus        : {gpr_fwd_valid, rd, wb_result, csr_busy}
module lsu #(
  parameter int EXU_LSU_W = 125,
  parameter int LSU_WBU_W = 117
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 excp_flush,
  input  logic                 mret_flush,
  input  logic                 exu_valid_i,
  input  logic [EXU_LSU_W-1:0] exu_lsu_bus_i,
  input  logic [6:0]           exu_excp_bus_i,
  output logic                 lsu_ready_o,
  lsu_if.master                axi,
  input  logic                 wbu_ready_i,
  output logic                 valid_o,
  output logic [LSU_WBU_W-1:0] lsu_wbu_bus_o,
  output logic [8:0]           lsu_excp_bus_o,
  output logic [38:0]          lsu_forward_bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT_R = 3'd1,
    WAIT_B = 3'd2,
    DONE   = 3'd3,
    DRAIN  = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic                   drain_r_q, drain_r_d;  // 1: draining an R beat, 0: a B beat
  logic [EXU_LSU_W-1:0]   bus_q, bus_d;
  logic [6:0]             excp_q, excp_d;
  logic [31:0]            loaded_q, loaded_d;
  logic                   load_fault_q, load_fault_d;
  logic                   store_fault_q, store_fault_d;

  // Load alignment: shift the addressed byte/half down, then extend by mem_re.
  function automatic logic [31:0] align_load(input logic [31:0] rdata,
                                             input logic [1:0]  mask,
                                             input logic [3:0]  re);
    logic [31:0] shifted;
    shifted = rdata >> {mask, 3'b000};
    case (re)
      4'b1111: align_load = shifted;
      4'b0011: align_load = {{16{shifted[15]}}, shifted[15:0]};
      4'b0111: align_load = {16'h0000, shifted[15:0]};
      4'b0001: align_load = {{24{shifted[7]}}, shifted[7:0]};
      4'b0101: align_load = {24'h000000, shifted[7:0]};
      default: align_load = 32'h0000_0000;
    endcase
  endfunction

  // Captured execute-bus fields (layout MSB..LSB as driven by execute).
  logic        skip_q, csr_we_q, mem_we_q, res_from_mem_q, gr_we_q, xret_q;
  logic [31:0] pc_q, csr_wdata_q, result_q;
  logic [1:0]  addr_mask_q;
  logic [3:0]  mem_re_q;
  logic [11:0] csr_addr_q;
  logic [4:0]  rd_q;
  assign skip_q         = bus_q[124];
  assign pc_q           = bus_q[123:92];
  assign csr_wdata_q    = bus_q[91:60];
  assign csr_we_q       = bus_q[59];
  assign addr_mask_q    = bus_q[58:57];
  assign mem_re_q       = bus_q[56:53];
  assign mem_we_q       = bus_q[52];
  assign csr_addr_q     = bus_q[51:40];
  assign res_from_mem_q = bus_q[39];
  assign gr_we_q        = bus_q[38];
  assign rd_q           = bus_q[37:33];
  assign xret_q         = bus_q[32];
  assign result_q       = bus_q[31:0];

  logic        flush_s, accept_s, drain_beat_s;
  logic [31:0] wb_result_s;
  logic        unused_resp_lsb_s;

  assign flush_s      = excp_flush | mret_flush;
  assign lsu_ready_o  = (state_q == IDLE) | ((state_q == DONE) & wbu_ready_i);
  assign accept_s     = exu_valid_i & lsu_ready_o & ~flush_s;
  assign drain_beat_s = drain_r_q ? axi.rvalid_i : axi.bvalid_i;
  assign unused_resp_lsb_s = axi.rresp_i[0] ^ axi.bresp_i[0];

  assign axi.rready_o = (state_q == WAIT_R) | ((state_q == DRAIN) & drain_r_q);
  assign axi.bready_o = (state_q == WAIT_B) | ((state_q == DRAIN) & ~drain_r_q);
  assign valid_o      = (state_q == DONE);

  assign wb_result_s     = res_from_mem_q ? loaded_q : result_q;
  assign lsu_wbu_bus_o   = {skip_q, pc_q, csr_wdata_q, csr_we_q, csr_addr_q,
                            gr_we_q, rd_q, xret_q, wb_result_s};
  assign lsu_excp_bus_o  = {load_fault_q, store_fault_q, excp_q};
  assign lsu_forward_bus = {valid_o & gr_we_q & (rd_q != 5'd0), rd_q, wb_result_s,
                            (state_q != IDLE) & csr_we_q};

  // Next-state and capture logic; flush takes priority over every transition.
  always_comb begin
    state_d       = state_q;
    drain_r_d     = drain_r_q;
    bus_d         = bus_q;
    excp_d        = excp_q;
    loaded_d      = loaded_q;
    load_fault_d  = load_fault_q;
    store_fault_d = store_fault_q;
    if (flush_s) begin
      case (state_q)
        // A beat coinciding with the flush is consumed here and dropped.
        WAIT_R: begin
          if (axi.rvalid_i) begin
            state_d = IDLE;
          end else begin
            state_d   = DRAIN;
            drain_r_d = 1'b1;
          end
        end
        WAIT_B: begin
          if (axi.bvalid_i) begin
            state_d = IDLE;
          end else begin
            state_d   = DRAIN;
            drain_r_d = 1'b0;
          end
        end
        DRAIN: begin
          if (drain_beat_s) begin
            state_d = IDLE;
          end else begin
            state_d = DRAIN;
          end
        end
        default: state_d = IDLE;
      endcase
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (accept_s) begin
            bus_d         = exu_lsu_bus_i;
            excp_d        = exu_excp_bus_i;
            load_fault_d  = 1'b0;
            store_fault_d = 1'b0;
            if (exu_lsu_bus_i[56:53] != 4'b0000) begin
              state_d = WAIT_R;
            end else if (exu_lsu_bus_i[52]) begin
              state_d = WAIT_B;
            end else begin
              state_d = DONE;
            end
          end else if ((state_q == DONE) & wbu_ready_i) begin
            state_d = IDLE;
          end else begin
            state_d = state_q;
          end
        end
        WAIT_R: begin
          if (axi.rvalid_i) begin
            loaded_d     = align_load(axi.rdata_i, addr_mask_q, mem_re_q);
            load_fault_d = axi.rresp_i[1];
            state_d      = DONE;
          end else begin
            state_d = WAIT_R;
          end
        end
        WAIT_B: begin
          if (axi.bvalid_i) begin
            store_fault_d = axi.bresp_i[1];
            state_d       = DONE;
          end else begin
            state_d = WAIT_B;
          end
        end
        DRAIN: begin
          if (drain_beat_s) begin
            state_d = IDLE;
          end else begin
            state_d = DRAIN;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and capture registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      drain_r_q     <= 1'b0;
      bus_q         <= '0;
      excp_q        <= 7'd0;
      loaded_q      <= 32'd0;
      load_fault_q  <= 1'b0;
      store_fault_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      drain_r_q     <= drain_r_d;
      bus_q         <= bus_d;
      excp_q        <= excp_d;
      loaded_q      <= loaded_d;
      load_fault_q  <= load_fault_d;
      store_fault_q <= store_fault_d;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu: loads of each width/extension, load
// and store faults, back-to-back ALU flow with write-back stall, flush drain,
// flush coinciding with a beat, flush in DONE, and reset mid-transaction.
module tb_lsu;
  logic         clock = 1'b0;
  logic         reset;
  logic         excp_flush, mret_flush;
  logic         exu_valid_i;
  logic [124:0] exu_lsu_bus_i;
  logic [6:0]   exu_excp_bus_i;
  logic         lsu_ready_o;
  logic         wbu_ready_i;
  logic         valid_o;
  logic [116:0] lsu_wbu_bus_o;
  logic [8:0]   lsu_excp_bus_o;
  logic [38:0]  lsu_forward_bus;
  int checks = 0;
  int failures = 0;

  lsu_if axi ();

  lsu dut (
    .clock(clock), .reset(reset), .excp_flush(excp_flush), .mret_flush(mret_flush),
    .exu_valid_i(exu_valid_i), .exu_lsu_bus_i(exu_lsu_bus_i), .exu_excp_bus_i(exu_excp_bus_i),
    .lsu_ready_o(lsu_ready_o), .axi(axi.master), .wbu_ready_i(wbu_ready_i),
    .valid_o(valid_o), .lsu_wbu_bus_o(lsu_wbu_bus_o), .lsu_excp_bus_o(lsu_excp_bus_o),
    .lsu_forward_bus(lsu_forward_bus)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [124:0] mk_exu(input logic [31:0] pc, input logic csr_we,
      input logic [1:0] mask, input logic [3:0] re, input logic we, input logic rfm,
      input logic gr_we, input logic [4:0] rd, input logic [31:0] result);
    return {1'b0, pc, pc ^ 32'hC5C5_0000, csr_we, mask, re, we, 12'h305, rfm, gr_we, rd, 1'b0, result};
  endfunction

  function automatic logic [116:0] mk_wbu(input logic [31:0] pc, input logic csr_we,
      input logic gr_we, input logic [4:0] rd, input logic [31:0] wb);
    return {1'b0, pc, pc ^ 32'hC5C5_0000, csr_we, 12'h305, gr_we, rd, 1'b0, wb};
  endfunction

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; excp_flush = 1'b0; mret_flush = 1'b0; exu_valid_i = 1'b0;
    exu_lsu_bus_i = '0; exu_excp_bus_i = 7'd0; wbu_ready_i = 1'b1;
    axi.rvalid_i = 1'b0; axi.rdata_i = 32'd0; axi.rresp_i = 2'd0;
    axi.bvalid_i = 1'b0; axi.bresp_i = 2'd0;
    step; step;
    reset = 1'b0;
    #1;
    checks++; if ({valid_o, axi.rready_o, axi.bready_o, lsu_ready_o} !== 4'b0001) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=0001", {valid_o, axi.rready_o, axi.bready_o, lsu_ready_o}); end
    checks++; if ({lsu_wbu_bus_o, lsu_excp_bus_o, lsu_forward_bus} !== '0) begin
      failures++; $display("FAIL reset_buses got=%h exp=0", {lsu_wbu_bus_o, lsu_excp_bus_o, lsu_forward_bus}); end
  endtask

  task automatic do_load(input string name, input logic [31:0] pc, input logic [1:0] mask,
      input logic [3:0] re, input logic [31:0] rdata, input logic [1:0] rresp,
      input int wait_cyc, input logic [31:0] exp_wb, input logic exp_lf);
    exu_valid_i = 1'b1; exu_excp_bus_i = 7'h15;
    exu_lsu_bus_i = mk_exu(pc, 1'b0, mask, re, 1'b0, 1'b1, 1'b1, 5'd7, 32'hDEAD_0000);
    #1;
    checks++; if (lsu_ready_o !== 1'b1) begin
      failures++; $display("FAIL %s idle_ready got=%b exp=1", name, lsu_ready_o); end
    step;
    exu_valid_i = 1'b0;
    for (int i = 0; i < wait_cyc; i++) begin
      checks++; if ({axi.rready_o, valid_o, lsu_forward_bus[38]} !== 3'b100) begin
        failures++; $display("FAIL %s wait%0d got=%b exp=100", name, i, {axi.rready_o, valid_o, lsu_forward_bus[38]}); end
      step;
    end
    axi.rvalid_i = 1'b1; axi.rdata_i = rdata; axi.rresp_i = rresp;
    #1;
    checks++; if ({axi.rready_o, valid_o} !== 2'b10) begin
      failures++; $display("FAIL %s beat got=%b exp=10", name, {axi.rready_o, valid_o}); end
    step;
    axi.rvalid_i = 1'b0;
    checks++; if ({valid_o, axi.rready_o} !== 2'b10) begin
      failures++; $display("FAIL %s done_ctrl got=%b exp=10", name, {valid_o, axi.rready_o}); end
    checks++; if (lsu_wbu_bus_o !== mk_wbu(pc, 1'b0, 1'b1, 5'd7, exp_wb)) begin
      failures++; $display("FAIL %s wb_bus got=%h exp=%h", name, lsu_wbu_bus_o, mk_wbu(pc, 1'b0, 1'b1, 5'd7, exp_wb)); end
    checks++; if (lsu_excp_bus_o !== {exp_lf, 1'b0, 7'h15}) begin
      failures++; $display("FAIL %s excp got=%h exp=%h", name, lsu_excp_bus_o, {exp_lf, 1'b0, 7'h15}); end
    checks++; if (lsu_forward_bus !== {1'b1, 5'd7, exp_wb, 1'b0}) begin
      failures++; $display("FAIL %s fwd got=%h exp=%h", name, lsu_forward_bus, {1'b1, 5'd7, exp_wb, 1'b0}); end
    step;
    checks++; if ({valid_o, lsu_ready_o} !== 2'b01) begin
      failures++; $display("FAIL %s retire got=%b exp=01", name, {valid_o, lsu_ready_o}); end
  endtask

  task automatic test_loads;
    do_load("lb",   32'h0000_1000, 2'b10, 4'b0001, 32'h12F4_5678, 2'b00, 3, 32'hFFFF_FFF4, 1'b0);
    do_load("lw_f", 32'h0000_1004, 2'b00, 4'b1111, 32'h0BAD_F00D, 2'b10, 0, 32'h0BAD_F00D, 1'b1);
    do_load("lhu",  32'h0000_1008, 2'b10, 4'b0111, 32'h8001_0000, 2'b00, 1, 32'h0000_8001, 1'b0);
    do_load("lh",   32'h0000_100C, 2'b00, 4'b0011, 32'h0000_8765, 2'b00, 0, 32'hFFFF_8765, 1'b0);
    do_load("lbu",  32'h0000_1010, 2'b11, 4'b0101, 32'hAB00_0000, 2'b00, 2, 32'h0000_00AB, 1'b0);
    do_load("bad",  32'h0000_1014, 2'b00, 4'b0010, 32'hFFFF_FFFF, 2'b00, 0, 32'h0000_0000, 1'b0);
  endtask

  task automatic do_store(input string name, input logic [1:0] bresp, input logic exp_sf);
    exu_valid_i = 1'b1; exu_excp_bus_i = 7'h00;
    exu_lsu_bus_i = mk_exu(32'h0000_2000, 1'b0, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0000_0040);
    step;
    exu_valid_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++; if ({axi.bready_o, axi.rready_o, valid_o} !== 3'b100) begin
        failures++; $display("FAIL %s wait%0d got=%b exp=100", name, i, {axi.bready_o, axi.rready_o, valid_o}); end
      step;
    end
    axi.bvalid_i = 1'b1; axi.bresp_i = bresp;
    step;
    axi.bvalid_i = 1'b0;
    checks++; if ({valid_o, axi.bready_o} !== 2'b10) begin
      failures++; $display("FAIL %s done got=%b exp=10", name, {valid_o, axi.bready_o}); end
    checks++; if (lsu_excp_bus_o !== {1'b0, exp_sf, 7'h00}) begin
      failures++; $display("FAIL %s excp got=%h exp=%h", name, lsu_excp_bus_o, {1'b0, exp_sf, 7'h00}); end
    checks++; if (lsu_wbu_bus_o[31:0] !== 32'h0000_0040) begin
      failures++; $display("FAIL %s wb got=%h exp=00000040", name, lsu_wbu_bus_o[31:0]); end
    step;
  endtask

  task automatic test_stores;
    do_store("st_ok", 2'b00, 1'b0);
    do_store("st_flt", 2'b11, 1'b1);
  endtask

  task automatic test_back_to_back;
    logic [4:0]  rd_t [5];
    logic [31:0] res_t [5];
    logic        csr_t [5];
    rd_t = '{5'd3, 5'd0, 5'd9, 5'd31, 5'd12};
    res_t = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004, 32'h5555_0005};
    csr_t = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    exu_valid_i = 1'b1;
    exu_lsu_bus_i = mk_exu(32'h3000, csr_t[0], 2'b00, 4'b0000, 1'b0, 1'b0, 1'b1, rd_t[0], res_t[0]);
    step;
    for (int i = 0; i < 4; i++) begin
      checks++; if (valid_o !== 1'b1 || lsu_wbu_bus_o !== mk_wbu(32'h3000 + 32'(4*i), csr_t[i], 1'b1, rd_t[i], res_t[i])) begin
        failures++; $display("FAIL b2b_%0d got=%b/%h exp=1/%h", i, valid_o, lsu_wbu_bus_o, mk_wbu(32'h3000 + 32'(4*i), csr_t[i], 1'b1, rd_t[i], res_t[i])); end
      checks++; if (lsu_forward_bus !== {rd_t[i] != 5'd0, rd_t[i], res_t[i], csr_t[i]}) begin
        failures++; $display("FAIL b2b_fwd_%0d got=%h exp=%h", i, lsu_forward_bus, {rd_t[i] != 5'd0, rd_t[i], res_t[i], csr_t[i]}); end
      exu_lsu_bus_i = mk_exu(32'h3000 + 32'(4*(i+1)), csr_t[i+1], 2'b00, 4'b0000, 1'b0, 1'b0, 1'b1, rd_t[i+1], res_t[i+1]);
      if (i < 3) step;
    end
    wbu_ready_i = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++; if ({lsu_ready_o, valid_o} !== 2'b01 || lsu_wbu_bus_o !== mk_wbu(32'h300C, 1'b0, 1'b1, 5'd31, res_t[3])) begin
        failures++; $display("FAIL stall_%0d got=%b/%h exp=01/%h", i, {lsu_ready_o, valid_o}, lsu_wbu_bus_o, mk_wbu(32'h300C, 1'b0, 1'b1, 5'd31, res_t[3])); end
      step;
    end
    wbu_ready_i = 1'b1;
    #1;
    checks++; if (lsu_ready_o !== 1'b1) begin
      failures++; $display("FAIL stall_release got=%b exp=1", lsu_ready_o); end
    step;
    exu_valid_i = 1'b0;
    checks++; if (valid_o !== 1'b1 || lsu_wbu_bus_o[31:0] !== res_t[4]) begin
      failures++; $display("FAIL after_stall got=%b/%h exp=1/%h", valid_o, lsu_wbu_bus_o[31:0], res_t[4]); end
    step;
    checks++; if ({valid_o, lsu_ready_o} !== 2'b01) begin
      failures++; $display("FAIL b2b_idle got=%b exp=01", {valid_o, lsu_ready_o}); end
  endtask

  task automatic test_flush_drain;
    exu_valid_i = 1'b1;
    exu_lsu_bus_i = mk_exu(32'h4000, 1'b0, 2'b00, 4'b1111, 1'b0, 1'b1, 1'b1, 5'd4, 32'd0);
    step;
    exu_valid_i = 1'b0; excp_flush = 1'b1;
    step;
    excp_flush = 1'b0;
    checks++; if ({axi.rready_o, valid_o, lsu_ready_o} !== 3'b100) begin
      failures++; $display("FAIL drain_1 got=%b exp=100", {axi.rready_o, valid_o, lsu_ready_o}); end
    step;
    axi.rvalid_i = 1'b1; axi.rdata_i = 32'h5A5A_5A5A; axi.rresp_i = 2'b00;
    #1;
    checks++; if ({axi.rready_o, valid_o, lsu_ready_o} !== 3'b100) begin
      failures++; $display("FAIL drain_beat got=%b exp=100", {axi.rready_o, valid_o, lsu_ready_o}); end
    step;
    axi.rvalid_i = 1'b0;
    checks++; if ({axi.rready_o, valid_o, lsu_ready_o} !== 3'b001) begin
      failures++; $display("FAIL drain_done got=%b exp=001", {axi.rready_o, valid_o, lsu_ready_o}); end
  endtask

  task automatic test_flush_with_beat;
    exu_valid_i = 1'b1;
    exu_lsu_bus_i = mk_exu(32'h5000, 1'b0, 2'b00, 4'b1111, 1'b0, 1'b1, 1'b1, 5'd4, 32'd0);
    step;
    exu_valid_i = 1'b0; mret_flush = 1'b1; axi.rvalid_i = 1'b1;
    #1;
    checks++; if (axi.rready_o !== 1'b1) begin
      failures++; $display("FAIL flush_beat_ready got=%b exp=1", axi.rready_o); end
    step;
    mret_flush = 1'b0; axi.rvalid_i = 1'b0;
    checks++; if ({axi.rready_o, valid_o, lsu_ready_o} !== 3'b001) begin
      failures++; $display("FAIL flush_beat_idle got=%b exp=001", {axi.rready_o, valid_o, lsu_ready_o}); end
    // Flush while a finished ALU result waits in DONE.
    exu_valid_i = 1'b1; wbu_ready_i = 1'b0;
    exu_lsu_bus_i = mk_exu(32'h5004, 1'b1, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b1, 5'd6, 32'h77);
    step;
    exu_valid_i = 1'b0;
    checks++; if ({valid_o, lsu_forward_bus[0]} !== 2'b11) begin
      failures++; $display("FAIL done_pre_flush got=%b exp=11", {valid_o, lsu_forward_bus[0]}); end
    mret_flush = 1'b1;
    step;
    mret_flush = 1'b0; wbu_ready_i = 1'b1;
    checks++; if ({valid_o, lsu_ready_o, lsu_forward_bus[0]} !== 3'b010) begin
      failures++; $display("FAIL done_flush got=%b exp=010", {valid_o, lsu_ready_o, lsu_forward_bus[0]}); end
  endtask

  task automatic test_reset_wait_b;
    exu_valid_i = 1'b1;
    exu_lsu_bus_i = mk_exu(32'h6000, 1'b0, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    step;
    exu_valid_i = 1'b0;
    checks++; if ({axi.bready_o, lsu_ready_o} !== 2'b10) begin
      failures++; $display("FAIL wait_b_pre got=%b exp=10", {axi.bready_o, lsu_ready_o}); end
    reset = 1'b1;
    step;
    reset = 1'b0;
    checks++; if ({valid_o, axi.bready_o, lsu_ready_o} !== 3'b001) begin
      failures++; $display("FAIL wait_b_reset got=%b exp=001", {valid_o, axi.bready_o, lsu_ready_o}); end
  endtask

  initial begin
    test_reset;
    test_loads;
    test_stores;
    test_back_to_back;
    test_flush_drain;
    test_flush_with_beat;
    test_reset_wait_b;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
